alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 38 +++
 rtl/alu_issue_imm_gen.sv | 16 +
 rtl/alu_issue.sv | 154 +++++++++++++++
 tb/tb_alu_issue.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and opcode constants for the RV32I ALU issue stage.
package alu_issue_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [31:0] register_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LUI,
    CLS_AUIPC,
    CLS_BAD
  } op_class_e;

  typedef struct packed {
    logic         valid;
    logic [4:0]   rd;
    instruction_t instr;
  } issue_slot_t;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    unique case (opcode)
      OP_R:     cls = CLS_R;
      OP_I:     cls = CLS_I;
      OP_LUI:   cls = CLS_LUI;
      OP_AUIPC: cls = CLS_AUIPC;
      default:  cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Immediate generation for the supported RV32I formats (I and U).
module imm_gen
  import alu_issue_pkg::*;
(
  input  instruction_t i_instr,
  output register_t    o_imm_i,
  output register_t    o_imm_u
);

  // Sign-extended I immediate and upper-20 U immediate
  always_comb begin
    o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    o_imm_u = {i_instr[31:12], 12'h000};
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, RAW stall against S1, forwarding from S2,
// registered ALU operands, writeback and retirement counting.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  instruction_t instr,
  input  register_t    instr_pc,
  output logic [4:0]   rs1_addr,
  output logic [4:0]   rs2_addr,
  input  register_t    rs1_data,
  input  register_t    rs2_data,
  output instruction_t alu_instr,
  output register_t    alu_op1,
  output register_t    alu_op2,
  output register_t    alu_pc,
  output logic         alu_enable,
  input  register_t    alu_result,
  output logic         wb_en,
  output logic [4:0]   wb_addr,
  output register_t    wb_data,
  output logic         illegal,
  output logic [31:0]  retired_count
);

  issue_slot_t r_s1;
  logic        r_s2_valid;
  logic [4:0]  r_s2_rd;
  register_t   r_alu_op1;
  register_t   r_alu_op2;
  register_t   r_alu_pc;
  logic        r_illegal;
  logic [31:0] r_retired;

  op_class_e   w_cls;
  logic        w_legal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_stall;
  logic        w_fwd1;
  logic        w_fwd2;
  logic        w_accept;
  register_t   w_src1;
  register_t   w_src2;
  register_t   w_imm_i;
  register_t   w_imm_u;
  register_t   w_op1;
  register_t   w_op2;

  imm_gen u_imm_gen (
    .i_instr (instr),
    .o_imm_i (w_imm_i),
    .o_imm_u (w_imm_u)
  );

  assign w_cls    = classify(instr[6:0]);
  assign w_legal  = (w_cls != CLS_BAD);
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Which source registers the offered instruction actually reads
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    unique case (w_cls)
      CLS_R:   begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      CLS_I:   w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // RAW hazard on S1 stalls; otherwise S2 result is forwarded over the RF read
  always_comb begin
    w_stall = r_s1.valid && (r_s1.rd != '0) &&
              ((w_use_rs1 && (rs1_addr == r_s1.rd)) ||
               (w_use_rs2 && (rs2_addr == r_s1.rd)));
    w_fwd1  = !w_stall && r_s2_valid && (r_s2_rd != '0) && (rs1_addr == r_s2_rd);
    w_fwd2  = !w_stall && r_s2_valid && (r_s2_rd != '0) && (rs2_addr == r_s2_rd);
    w_src1  = w_fwd1 ? alu_result : rs1_data;
    w_src2  = w_fwd2 ? alu_result : rs2_data;
  end

  assign instr_ready = rst && !w_stall;
  assign w_accept    = instr_valid && instr_ready;

  // Operand selection per instruction class
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    unique case (w_cls)
      CLS_R:     begin w_op1 = w_src1;  w_op2 = w_src2;  end
      CLS_I:     begin w_op1 = w_src1;  w_op2 = w_imm_i; end
      CLS_LUI,
      CLS_AUIPC: w_op1 = w_imm_u;
      default:   ;
    endcase
  end

  // Pipeline slots: S1 loads on legal accept, S2 always follows S1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rd    <= '0;
    end else begin
      r_s1.valid <= w_accept && w_legal;
      if (w_accept && w_legal) begin
        r_s1.rd    <= instr[11:7];
        r_s1.instr <= instr;
      end
      r_s2_valid <= r_s1.valid;
      r_s2_rd    <= r_s1.rd;
    end
  end

  // Registered ALU operands, held between legal accepts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_op1 <= '0;
      r_alu_op2 <= '0;
      r_alu_pc  <= '0;
    end else if (w_accept && w_legal) begin
      r_alu_op1 <= w_op1;
      r_alu_op2 <= w_op2;
      r_alu_pc  <= instr_pc;
    end
  end

  // One-cycle illegal pulse and retirement counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (wb_en) r_retired <= r_retired + 32'd1;
    end
  end

  assign alu_instr     = r_s1.instr;
  assign alu_op1       = r_alu_op1;
  assign alu_op2       = r_alu_op2;
  assign alu_pc        = r_alu_pc;
  assign alu_enable    = r_s1.valid;
  assign wb_en         = r_s2_valid && (r_s2_rd != '0);
  assign wb_addr       = r_s2_rd;
  assign wb_data       = alu_result;
  assign illegal       = r_illegal;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: bench-side register file and ALU, and an in-order
// architectural reference model predicting every writeback and its cycle.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  instruction_t instr = '0;
  register_t    instr_pc = '0;
  logic [4:0]   rs1_addr, rs2_addr;
  register_t    rs1_data, rs2_data;
  instruction_t alu_instr;
  register_t    alu_op1, alu_op2, alu_pc;
  logic         alu_enable;
  register_t    alu_result;
  logic         wb_en;
  logic [4:0]   wb_addr;
  register_t    wb_data;
  logic         illegal;
  logic [31:0]  retired_count;

  alu_issue dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .alu_instr     (alu_instr),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_pc        (alu_pc),
    .alu_enable    (alu_enable),
    .alu_result    (alu_result),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  function automatic register_t op_fn(input logic [2:0] f3, input logic sub,
                                      input register_t a, input register_t b);
    case (f3)
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return sub ? a - b : a + b;
    endcase
  endfunction

  // Environment: register file and single-cycle registered ALU
  register_t rf [32];
  register_t alu_res;
  assign rs1_data   = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
  assign rs2_data   = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];
  assign alu_result = alu_res;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      alu_res <= '0;
    end else begin
      if (wb_en) rf[wb_addr] <= wb_data;
      if (alu_enable) begin
        case (alu_instr[6:0])
          OP_LUI:   alu_res <= alu_op1 + alu_op2;
          OP_AUIPC: alu_res <= alu_pc + alu_op1;
          OP_R:     alu_res <= op_fn(alu_instr[14:12], alu_instr[30], alu_op1, alu_op2);
          default:  alu_res <= op_fn(alu_instr[14:12], 1'b0, alu_op1, alu_op2);
        endcase
      end
    end
  end

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    register_t   val;
    int unsigned due;
  } wb_t;

  register_t   greg [32];
  wb_t         q [$];
  int unsigned cyc = 0;
  int unsigned exp_ret = 0;
  int unsigned wb_seen = 0;
  logic        pend_en = 1'b0;
  logic        pend_ill = 1'b0;
  logic        s1v = 1'b0;
  logic [4:0]  s1rd = '0;
  int          checks = 0;
  int          failures = 0;

  function automatic bit is_legal(input instruction_t ins);
    return ins[6:0] == OP_R || ins[6:0] == OP_I || ins[6:0] == OP_LUI || ins[6:0] == OP_AUIPC;
  endfunction

  function automatic register_t golden(input instruction_t ins, input register_t pc);
    register_t u;
    u = {ins[31:12], 12'h000};
    case (ins[6:0])
      OP_LUI:   return u;
      OP_AUIPC: return pc + u;
      OP_R:     return op_fn(ins[14:12], ins[30], greg[ins[19:15]], greg[ins[24:20]]);
      default:  return op_fn(ins[14:12], 1'b0, greg[ins[19:15]], {{20{ins[31]}}, ins[31:20]});
    endcase
  endfunction

  function automatic bit exp_ready(input instruction_t ins);
    bit u1, u2;
    u1 = (ins[6:0] == OP_R) || (ins[6:0] == OP_I);
    u2 = (ins[6:0] == OP_R);
    if (!rst) return 1'b0;
    return !(s1v && s1rd != 5'd0 &&
             ((u1 && ins[19:15] == s1rd) || (u2 && ins[24:20] == s1rd)));
  endfunction

  function automatic instruction_t i_type(input int rd, input int rs1, input logic [2:0] f3,
                                          input logic [11:0] imm);
    return {imm, 5'(rs1), f3, 5'(rd), OP_I};
  endfunction

  function automatic instruction_t r_type(input int rd, input int rs1, input int rs2,
                                          input logic [2:0] f3, input logic sub);
    return {1'b0, sub, 5'b0, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_R};
  endfunction

  function automatic instruction_t u_type(input logic [6:0] op, input int rd, input logic [19:0] imm);
    return {imm, 5'(rd), op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then check the cycle's outputs
  task automatic tick();
    logic rdy, acc;
    instruction_t ins;
    register_t pc, v;
    wb_t e;
    bit exp_wb;
    rdy = instr_ready;
    ins = instr;
    pc  = instr_pc;
    acc = instr_valid && rdy;
    @(posedge clk);
    cyc++;
    pend_en  = 1'b0;
    pend_ill = 1'b0;
    s1v      = 1'b0;
    if (acc) begin
      if (is_legal(ins)) begin
        pend_en = 1'b1;
        s1v     = 1'b1;
        s1rd    = ins[11:7];
        v = golden(ins, pc);
        if (ins[11:7] != 5'd0) begin
          e.rd = ins[11:7]; e.val = v; e.due = cyc + 1;
          q.push_back(e);
          greg[ins[11:7]] = v;
        end
      end else begin
        pend_ill = 1'b1;
      end
    end
    #1;
    chkb("alu_enable", alu_enable, pend_en);
    chkb("illegal", illegal, pend_ill);
    chk("retired_count", retired_count, exp_ret);
    exp_wb = (q.size() > 0) && (q[0].due == cyc);
    chkb("wb_en", wb_en, exp_wb);
    if (wb_en === 1'b1) wb_seen++;
    if (exp_wb) begin
      chk("wb_addr", {27'b0, wb_addr}, {27'b0, q[0].rd});
      chk("wb_data", wb_data, q[0].val);
      void'(q.pop_front());
      exp_ret++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic offer(input instruction_t ins, input register_t pc, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    instr_valid = 1'b1;
    instr       = ins;
    instr_pc    = pc;
    for (int t = 0; t < 4 && !done; t++) begin
      #1;
      chkb("instr_ready", instr_ready, exp_ready(ins));
      if (instr_ready === 1'b1) done = 1'b1;
      else stalls++;
      tick();
    end
    instr_valid = 1'b0;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL offer_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    instr_valid = 1'b1;
    #1;
    q.delete();
    for (int i = 0; i < 32; i++) greg[i] = '0;
    s1v = 1'b0; pend_en = 1'b0; pend_ill = 1'b0; exp_ret = 0;
    chkb("rst_instr_ready", instr_ready, 1'b0);
    chkb("rst_alu_enable", alu_enable, 1'b0);
    chkb("rst_wb_en", wb_en, 1'b0);
    chkb("rst_illegal", illegal, 1'b0);
    chk("rst_alu_op1", alu_op1, '0);
    chk("rst_alu_op2", alu_op2, '0);
    chk("rst_alu_pc", alu_pc, '0);
    chk("rst_alu_instr", alu_instr, '0);
    chk("rst_retired", retired_count, '0);
    instr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int st;
    int unsigned base;
    instruction_t w;
    logic [6:0] bad_ops [3];
    logic [2:0] f3s [4];
    logic [2:0] f3;
    bad_ops = '{7'h7F, 7'h03, 7'h63};
    f3s     = '{3'd0, 3'd4, 3'd6, 3'd7};

    @(negedge clk);
    do_reset();

    // RAW on S1: one bubble, then S2 forwarding supplies both operands
    offer(i_type(1, 0, 3'd0, 12'd5), 32'h0, st);
    offer(r_type(2, 1, 1, 3'd0, 1'b0), 32'h4, st);
    chk("raw_bubbles", st, 1);
    idle(3);
    chk("x2_after_fwd", rf[2], 32'd10);

    // LUI / AUIPC
    offer(u_type(OP_LUI, 3, 20'h12345), 32'h0FC, st);
    offer(u_type(OP_AUIPC, 4, 20'h00001), 32'h100, st);
    chk("auipc_no_stall", st, 0);
    idle(3);
    chk("x3_lui", rf[3], 32'h12345000);
    chk("x4_auipc", rf[4], 32'h00001100);

    // Write to x0: enable pulses, no writeback, count unchanged
    base = exp_ret;
    offer(i_type(0, 0, 3'd0, 12'd7), 32'h104, st);
    idle(3);
    chk("x0_retired", retired_count, base);

    // Illegal opcode then a normal instruction
    offer(32'h0000_007F, 32'h108, st);
    offer(i_type(6, 0, 3'd0, 12'd9), 32'h10C, st);
    chk("after_illegal_no_stall", st, 0);
    idle(3);
    chk("x6_after_illegal", rf[6], 32'd9);

    // Eight independent back-to-back ADDIs from a clean reset
    @(negedge clk);
    do_reset();
    base = wb_seen;
    for (int i = 0; i < 8; i++) begin
      offer(i_type(i + 1, 0, 3'd0, 12'(i * 3 + 1)), 32'(i * 4), st);
      chk("stream_no_stall", st, 0);
    end
    idle(3);
    chk("stream_wb_cycles", wb_seen - base, 8);
    chk("stream_retired", retired_count, 8);

    // Reset in the S1 cycle of an accepted instruction
    offer(i_type(5, 0, 3'd0, 12'd3), 32'h0, st);
    do_reset();
    idle(4);
    chk("flush_retired", retired_count, 0);
    chk("flush_x5", rf[5], 0);

    // Randomized stream with hazards, gaps and illegal words
    for (int n = 0; n < 300; n++) begin
      int k;
      k  = int'($urandom_range(0, 9));
      f3 = f3s[$urandom_range(0, 3)];
      case (k)
        0: w = u_type(OP_LUI, int'($urandom_range(0, 7)), 20'($urandom()));
        1: w = u_type(OP_AUIPC, int'($urandom_range(0, 7)), 20'($urandom()));
        2: begin w = $urandom(); w[6:0] = bad_ops[$urandom_range(0, 2)]; end
        3, 4, 5: w = r_type(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)), f3, (f3 == 3'd0) ? 1'($urandom()) : 1'b0);
        default: w = i_type(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), f3,
                            12'($urandom()));
      endcase
      offer(w, $urandom() & 32'h0000_FFFC, st);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    for (int i = 0; i < 8; i++) chk("final_regfile", rf[i], greg[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
